// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the MIPS instruction encoder: opcodes, FSM states and
// field bit positions (same positions the control decoder slices).
package instr_encoder_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    HALT  = 2'd2
  } state_e;

  localparam int OP_LSB     = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_LSB    = 0;
  localparam int TARGET_LSB = 0;

  function automatic logic is_jump(input logic [5:0] code);
    return (code == OP_J) || (code == OP_JAL);
  endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational field packer: builds a 32-bit MIPS word from a unified opcode
// and operand fields, and flags requests that would decode as R-type by mistake.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic        rtype_i,
  input  logic [5:0]  code_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  always_comb begin
    word_o    = '0;
    // A non-R request with opcode 0 would be read back as an R-type word.
    illegal_o = !rtype_i && (code_i == OP_RTYPE);
    if (rtype_i) begin
      word_o[OP_LSB +: 6]    = OP_RTYPE;
      word_o[RS_LSB +: 5]    = rs_i;
      word_o[RT_LSB +: 5]    = rt_i;
      word_o[RD_LSB +: 5]    = rd_i;
      word_o[SHAMT_LSB +: 5] = shamt_i;
      word_o[FUNCT_LSB +: 6] = code_i;
    end else if (is_jump(code_i)) begin
      word_o[OP_LSB +: 6]      = code_i;
      word_o[TARGET_LSB +: 26] = target_i;
    end else begin
      word_o[OP_LSB +: 6]   = code_i;
      word_o[RS_LSB +: 5]   = rs_i;
      word_o[RT_LSB +: 5]   = rt_i;
      word_o[IMM_LSB +: 16] = imm_i;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: encodes instructions and streams them into instruction
// memory at consecutive word addresses, one word per two cycles.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int          DEPTH     = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_rtype,
  input  logic [5:0]  in_code,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_shamt,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic [10:0] count,
  output logic        full,
  output logic        err
);

  localparam logic [10:0] DEPTH_C = 11'(DEPTH);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] word_q, word_d;
  logic [10:0] count_q, count_d;
  logic        err_q, err_d;
  logic [31:0] pack_word;
  logic        pack_illegal;
  logic        accept;

  instr_pack u_pack (
    .rtype_i   (in_rtype),
    .code_i    (in_code),
    .rs_i      (in_rs),
    .rt_i      (in_rt),
    .rd_i      (in_rd),
    .shamt_i   (in_shamt),
    .imm_i     (in_imm),
    .target_i  (in_target),
    .word_o    (pack_word),
    .illegal_o (pack_illegal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= BASE_ADDR;
      word_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    word_d   = word_q;
    count_d  = count_q;
    err_d    = err_q;
    full     = (count_q == DEPTH_C);
    in_ready = !reset && (state_q == IDLE) && !full;
    im_we    = (state_q == WRITE);
    accept   = in_valid && in_ready;

    // start outranks everything; a write already on the bus this cycle still lands.
    if (start) begin
      state_d = IDLE;
      addr_d  = BASE_ADDR;
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (pack_illegal) begin
              err_d = 1'b1;
            end else begin
              word_d  = pack_word;
              state_d = WRITE;
            end
          end
        end
        WRITE: begin
          addr_d  = addr_q + 32'd4;
          count_d = count_q + 11'd1;
          state_d = ((count_q + 11'd1) == DEPTH_C) ? HALT : IDLE;
        end
        HALT: begin
          state_d = HALT;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign im_addr  = addr_q;
  assign im_wdata = word_q;
  assign count    = count_q;
  assign err      = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder (DEPTH=4 build) with a transaction-level
// reference model compared every cycle plus literal checks on known encodings.
module tb_instr_encoder;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_rtype = 1'b0;
  logic [5:0]  in_code = '0;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;
  logic        im_we;
  logic [31:0] im_addr, im_wdata;
  logic [10:0] count;
  logic        full, err;

  int tests = 0;
  int fails = 0;

  instr_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_rtype(in_rtype), .in_code(in_code),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_target(in_target),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .count(count), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding from the MIPS field layout, by plain arithmetic.
  function automatic logic [31:0] model_enc(input logic rt, input logic [5:0] code,
      input logic [4:0] rs, input logic [4:0] rtf, input logic [4:0] rd,
      input logic [4:0] sh, input logic [15:0] imm, input logic [25:0] tgt);
    int unsigned w;
    if (rt)
      w = rs * (2**21) + rtf * (2**16) + rd * (2**11) + sh * (2**6) + code;
    else if (code == 6'h02 || code == 6'h03)
      w = code * (2**26) + tgt;
    else
      w = code * (2**26) + rs * (2**21) + rtf * (2**16) + imm;
    return w;
  endfunction

  // Model: words written so far, sticky error, and whether a word is on the bus now.
  int          m_count;
  bit          m_err, m_wr, m_rtype;
  logic [31:0] m_word;
  logic [5:0]  m_code;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_count <= 0; m_err <= 0; m_wr <= 0;
    end else if (start) begin
      m_count <= 0; m_err <= 0; m_wr <= 0;
    end else if (m_wr) begin
      m_count <= m_count + 1; m_wr <= 0;
    end else if (in_valid && m_count < DEPTH) begin
      if (!in_rtype && in_code == 6'h00) m_err <= 1;
      else begin
        m_wr    <= 1;
        m_word  <= model_enc(in_rtype, in_code, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target);
        m_code  <= in_code;
        m_rtype <= in_rtype;
      end
    end
  end

  logic [5:0] dec_op;
  assign dec_op = im_wdata[31:26];

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_ready", in_ready, 0);
      chk("rst_we", im_we, 0);
      chk("rst_addr", im_addr, BASE);
      chk("rst_wdata", im_wdata, 0);
      chk("rst_count", count, 0);
      chk("rst_full", full, 0);
      chk("rst_err", err, 0);
    end else begin
      chk("ready", in_ready, (!m_wr && m_count < DEPTH));
      chk("we", im_we, m_wr);
      chk("addr", im_addr, 32'(BASE + 4 * m_count));
      chk("count", count, m_count);
      chk("full", full, (m_count == DEPTH));
      chk("err", err, m_err);
      if (m_wr) begin
        chk("wdata", im_wdata, m_word);
        chk("dec_funout", (dec_op == 6'h00) ? im_wdata[5:0] : dec_op, m_code);
        chk("dec_opout", (dec_op != 6'h00), !m_rtype);
      end
    end
  end

  // Present one request, wait (bounded) for in_ready, complete the handshake.
  // Entered and left at posedge+1.
  task automatic send(input logic rt, input logic [5:0] code, input logic [4:0] rs,
      input logic [4:0] rtf, input logic [4:0] rd, input logic [4:0] sh,
      input logic [15:0] imm, input logic [25:0] tgt);
    bit ok = 0;
    in_rtype = rt; in_code = code; in_rs = rs; in_rt = rtf; in_rd = rd;
    in_shamt = sh; in_imm = imm; in_target = tgt; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL send_timeout: in_ready got 0 expected 1 within 20 cycles");
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic pulse_start;
    start = 1'b1; tick(); start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("post_rst_ready", in_ready, 1);

    // addu $3,$1,$2
    send(1, 6'h21, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    chk("addu_we", im_we, 1);
    chk("addu_word", im_wdata, 32'h0022_1821);
    chk("addu_addr", im_addr, 32'h0000_3000);
    chk("addu_busy", in_ready, 0);

    // ori $1,$0,0x1234 (stray rd/target must not leak in)
    send(0, 6'h0D, 5'd0, 5'd1, 5'd7, 5'd3, 16'h1234, 26'h3FF_FFFF);
    chk("ori_word", im_wdata, 32'h3401_1234);
    chk("ori_addr", im_addr, 32'h0000_3004);
    tick();
    chk("ori_count", count, 2);
    chk("ori_one_cycle_we", im_we, 0);

    // jal 0xC00, then an illegal non-R opcode 0
    send(0, 6'h03, 5'd31, 5'd31, 5'd0, 5'd0, 16'hFFFF, 26'h000_0C00);
    chk("jal_word", im_wdata, 32'h0C00_0C00);
    chk("jal_addr", im_addr, 32'h0000_3008);
    send(0, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 16'h5, 26'h0);
    chk("illegal_we", im_we, 0);
    chk("illegal_err", err, 1);
    chk("illegal_count", count, 3);

    pulse_start();
    chk("start_count", count, 0);
    chk("start_err", err, 0);

    // Fill to DEPTH
    for (int i = 0; i < DEPTH; i++)
      send(0, 6'h0D, 5'd2, 5'd4, 5'd0, 5'd0, 16'(i), 26'h0);
    tick();
    chk("full_flag", full, 1);
    chk("full_ready", in_ready, 0);
    chk("full_count", count, 4);

    // Fifth word is held off while full
    in_rtype = 0; in_code = 6'h23; in_rs = 5'd29; in_rt = 5'd8; in_imm = 16'h0010;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("held_we", im_we, 0);
    end
    pulse_start();
    tick();
    in_valid = 1'b0;
    chk("after_full_we", im_we, 1);
    chk("after_full_addr", im_addr, 32'h0000_3000);
    chk("lw_word", im_wdata, 32'h8FA8_0010);
    tick();

    // start coinciding with an accept drops the request
    in_valid = 1'b1; in_code = 6'h0D; start = 1'b1;
    tick();
    in_valid = 1'b0; start = 1'b0;
    chk("drop_we", im_we, 0);
    chk("drop_count", count, 0);

    // start during WRITE: write finishes at the old address, then rewind
    send(0, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    chk("err_set", err, 1);
    send(0, 6'h0D, 5'd0, 5'd1, 5'd0, 5'd0, 16'h0001, 26'h0);
    tick();
    send(1, 6'h21, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0);
    chk("midwr_addr", im_addr, 32'h0000_3004);
    chk("midwr_we", im_we, 1);
    pulse_start();
    chk("rewind_addr", im_addr, 32'h0000_3000);
    chk("rewind_count", count, 0);
    chk("rewind_err", err, 0);
    send(0, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h123_4567);
    chk("rewind_next_addr", im_addr, 32'h0000_3000);
    chk("j_word", im_wdata, 32'h0923_4567);
    tick();
    chk("rewind_next_count", count, 1);

    // Asynchronous reset in the middle of a write
    send(1, 6'h21, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    chk("pre_rst_we", im_we, 1);
    reset = 1'b1;
    #1;
    chk("async_rst_we", im_we, 0);
    chk("async_rst_ready", in_ready, 0);
    chk("async_rst_addr", im_addr, BASE);
    chk("async_rst_wdata", im_wdata, 0);
    chk("async_rst_count", count, 0);
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("final_ready", in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
